// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-stream slice.
//   WIDTH_DEF : default data width of the FIFO read port / output stream
//   CNT_W     : width of the optional transfer counter
//   occ_t     : output-buffer occupancy (0..2)
`timescale 1ns/1ps
package fifo_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W     = 16;
   typedef logic [1:0] occ_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer sitting behind a 1-cycle-latency FIFO read port.
// Ports:
//   clk_r, rst_n        : clock, async active-low reset
//   push, push_data     : write one word at the tail
//   pop                 : retire the head word
//   occ                 : current occupancy (0..2)
//   valid               : registered (occ != 0)
//   head_data           : head entry (0 out of reset)
`timescale 1ns/1ps
module fifo_rd_skid
   import fifo_pkg::*;
#(
   parameter int width = WIDTH_DEF
) (
   input  logic             clk_r,
   input  logic             rst_n,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output occ_t             occ,
   output logic             valid,
   output logic [width-1:0] head_data
);

   logic [width-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   occ_t             occ_nxt;

   // push and pop in the same cycle cancel out
   assign occ_nxt   = occ + occ_t'(push) - occ_t'(pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= '0;
         valid  <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ   <= occ_nxt;
         valid <= (occ_nxt != '0);
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a FIFO pop interface (registered read data, 1-cycle latency) into
// a full-throughput valid/ready stream.
// Ports:
//   clk_r, rst_n  : clock, async active-low reset
//   fifo_empty    : FIFO empty flag
//   fifo_data     : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    : FIFO read request (combinational)
//   m_data/m_valid/m_ready : output stream
//   xfer_cnt      : beat counter, only with FIFO_RD_STREAM_CNT_EN defined
`timescale 1ns/1ps
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int width = WIDTH_DEF
) (
   input  logic             clk_r,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [width-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic [width-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
   ,
   output logic [CNT_W-1:0] xfer_cnt
`endif
);

   occ_t       occ;
   logic       inflight;
   logic       run;
   logic       pop;
   logic [2:0] fill_nxt;

   assign pop = m_valid && m_ready;

   // Buffer slots committed after this edge: held words plus the word
   // arriving now, minus the one leaving. pop implies occ>=1, so no underflow.
   assign fill_nxt = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

   // run holds off issue until one edge has been seen out of reset, so a
   // read is never requested in the partial cycle during reset release.
   assign fifo_rd_en = run && !fifo_empty && (fill_nxt < 3'd2);

   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n) begin
         run      <= 1'b0;
         inflight <= 1'b0;
      end else begin
         run      <= 1'b1;
         inflight <= fifo_rd_en;
      end
   end

   fifo_rd_skid #(.width(width)) u_skid (
      .clk_r     (clk_r),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_data),
      .pop       (pop),
      .occ       (occ),
      .valid     (m_valid),
      .head_data (m_data)
   );

`ifdef FIFO_RD_STREAM_CNT_EN
   always_ff @(posedge clk_r or negedge rst_n) begin
      if (!rst_n)   xfer_cnt <= '0;
      else if (pop) xfer_cnt <= xfer_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
`timescale 1ns/1ps
module tb_fifo_rd_stream;
   localparam int W = 32;

   logic          clk_r = 1'b0;
   logic          rst_n;
   logic          fifo_empty = 1'b1;
   logic [W-1:0]  fifo_data  = '0;
   logic          fifo_rd_en;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          m_ready;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [15:0]   xfer_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int beats  = 0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];

   always #5 clk_r = ~clk_r;

   fifo_rd_stream #(.width(W)) dut (
      .clk_r      (clk_r),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready)
`ifdef FIFO_RD_STREAM_CNT_EN
      ,
      .xfer_cnt   (xfer_cnt)
`endif
   );

   // FIFO model: registered read data, empty flag updated on the clock
   always @(posedge clk_r) begin
      if (fifo_rd_en) fifo_data <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
   end

   task automatic push(input logic [W-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   task automatic wait_drain(input int lim, input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < lim) begin
         @(negedge clk_r);
         n++;
      end
      @(negedge clk_r);
      chk(tag, exp_q.size(), 0);
   endtask

   // Stream monitor: scoreboard compare on each beat, hold check on stalls
   task automatic mon_loop();
      logic [W-1:0] prev_d;
      logic [W-1:0] e;
      logic         stalled;
      stalled = 1'b0;
      prev_d  = '0;
      forever begin
         @(negedge clk_r);
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled && m_valid) begin
               checks++;
               assert (m_data === prev_d) else begin
                  errors++;
                  $error("FAIL hold got %h want %h", m_data, prev_d);
               end
            end
            if (m_valid && m_ready) begin
               beats++;
               checks++;
               assert (exp_q.size() != 0) else begin
                  errors++;
                  $error("FAIL beat_extra got %h want no beat", m_data);
               end
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  checks++;
                  assert (m_data === e) else begin
                     errors++;
                     $error("FAIL beat_data got %h want %h", m_data, e);
                  end
               end
            end
            stalled = m_valid && !m_ready;
            prev_d  = m_data;
         end
      end
   endtask

   initial begin
      int n;
      int rd;
      int b0;
      rst_n   = 1'b0;
      m_ready = 1'b1;
      fork
         mon_loop();
      join_none

      // reset state, FIFO already holding data
      repeat (2) @(negedge clk_r);
      push(32'h11); push(32'h22); push(32'h33);
      repeat (3) @(negedge clk_r);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data", m_data, 0);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);

      // release mid-cycle: no read before the first edge with rst_n=1
      @(posedge clk_r); #1 rst_n = 1'b1;
      @(negedge clk_r);
      chk("rel_no_rd", 32'(fifo_rd_en), 0);

      // first-beat latency and back-to-back beats
      n = 0;
      while (!fifo_rd_en && n < 10) begin
         @(negedge clk_r);
         n++;
      end
      chk("first_rd", 32'(fifo_rd_en), 1);
      @(negedge clk_r); chk("lat_n1", 32'(m_valid), 0);
      @(negedge clk_r); chk("lat_n2", 32'(m_valid), 1);
      @(negedge clk_r); chk("lat_n3", 32'(m_valid), 1);
      @(negedge clk_r); chk("lat_n4", 32'(m_valid), 1);
      @(negedge clk_r); chk("lat_n5", 32'(m_valid), 0);
      chk("t1_drained", exp_q.size(), 0);

      // sink stalled: only two reads issued, head held
      @(posedge clk_r); #1 m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(32'hA0 + 32'(i));
      rd = 0;
      repeat (8) begin
         @(negedge clk_r);
         if (fifo_rd_en) rd++;
      end
      chk("stall_reads", rd, 2);
      chk("stall_valid", 32'(m_valid), 1);
      chk("stall_head", m_data, 32'hA0);
      @(posedge clk_r); #1 m_ready = 1'b1;
      wait_drain(30, "stall_drain");

      // toggling ready over a 16-word stream
      b0 = beats;
      for (int i = 0; i < 16; i++) push(32'(i));
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk_r); #1 m_ready = ~m_ready;
         n++;
      end
      @(posedge clk_r); #1 m_ready = 1'b1;
      @(negedge clk_r);
      chk("toggle_beats", beats - b0, 16);
      chk("toggle_drained", exp_q.size(), 0);

      // empty FIFO: nothing requested, nothing emitted
      repeat (20) begin
         @(negedge clk_r);
         chk("empty_rd", 32'(fifo_rd_en), 0);
         chk("empty_valid", 32'(m_valid), 0);
      end

      // reset with one word buffered and one in flight
      @(posedge clk_r); #1 m_ready = 1'b0;
      push(32'hC0); push(32'hC1); push(32'hC2);
      n = 0;
      while (!m_valid && n < 10) begin
         @(negedge clk_r);
         n++;
      end
      chk("pre_rst_valid", 32'(m_valid), 1);
      fifo_q.delete();
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(m_valid), 0);
      chk("mid_rst_data", m_data, 0);
      chk("mid_rst_rd_en", 32'(fifo_rd_en), 0);
      repeat (2) @(posedge clk_r);
      #1 rst_n = 1'b1; m_ready = 1'b1;
      b0 = beats;
      repeat (10) begin
         @(negedge clk_r);
         chk("post_rst_valid", 32'(m_valid), 0);
      end
      chk("post_rst_beats", beats - b0, 0);

`ifdef FIFO_RD_STREAM_CNT_EN
      chk("cnt_rst", {16'h0, xfer_cnt}, 0);
      for (int i = 0; i < 65537; i++) push(32'(i));
      wait_drain(70000, "cnt_drain");
      chk("cnt_wrap", {16'h0, xfer_cnt}, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
